// File: rtl/alu_op_dispatcher.sv
// alu_op_dispatcher: request FIFO feeding a launch/wait/respond sequencer with watchdog for the ALU control unit.
// Define ALU_DISP_STATS_EN to add the stat_done/stat_tmo response counters.
module alu_op_dispatcher #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  output logic             cu_start,
  output logic [1:0]       cu_op,
  output logic [WIDTH-1:0] op_x,
  output logic [WIDTH-1:0] op_y,
  input  logic             cu_finish,
  input  logic [WIDTH-1:0] dp_hi,
  input  logic [WIDTH-1:0] dp_lo,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_op,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  output logic             rsp_timeout
`ifdef ALU_DISP_STATS_EN
  , output logic [15:0]    stat_done,
  output logic [7:0]       stat_tmo
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam int EW = 2 + 2 * WIDTH;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_nx;
  logic [CW-1:0] wd;
  logic full, push, pop, tmo, done;
  assign push = req_valid & ~full;
  assign pop = (state == IDLE) && (count != '0);
  // ready drops combinationally with reset so it reads 0 while held, 1 right after release
  assign req_ready = rst & ~full;
  assign count_nx = count + (AW+1)'(push) - (AW+1)'(pop);
  assign tmo = wd == CW'(TIMEOUT - 1);
  assign done = (state == WAIT) && (cu_finish || tmo);
  assign cu_start = state == LAUNCH;
  assign rsp_valid = state == RESP;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = pop ? LAUNCH : IDLE;
      LAUNCH:  state_nx = WAIT;
      WAIT:    state_nx = done ? RESP : WAIT;
      default: state_nx = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {req_op, req_x, req_y};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      wd <= '0;
      cu_op <= '0;
      op_x <= '0;
      op_y <= '0;
      rsp_op <= '0;
      rsp_hi <= '0;
      rsp_lo <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        {cu_op, op_x, op_y} <= mem[rd_ptr];
      end
      count <= count_nx;
      full <= count_nx == (AW+1)'(DEPTH);
      // stops at TIMEOUT-1 because WAIT exits there, so it never wraps
      wd <= (state == WAIT && !tmo) ? wd + CW'(1) : '0;
      if (done) begin
        rsp_op <= cu_op;
        rsp_hi <= cu_finish ? dp_hi : '0;
        rsp_lo <= cu_finish ? dp_lo : '0;
        rsp_timeout <= ~cu_finish;
      end
    end
  end
`ifdef ALU_DISP_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_done <= '0;
      stat_tmo <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (!rsp_timeout) stat_done <= stat_done + 16'd1;
      else if (stat_tmo != 8'hff) stat_tmo <= stat_tmo + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_op_dispatcher.sv
// tb_alu_op_dispatcher: directed and randomized checks of alu_op_dispatcher against a queue-based request/response model.
module tb_alu_op_dispatcher;
  localparam int W = 8;
  localparam int TMO = 64;
  typedef struct packed {logic [1:0] op; logic [W-1:0] x; logic [W-1:0] y;} req_t;
  logic clk = 0, rst = 0;
  logic req_valid = 0, req_ready;
  logic [1:0] req_op = 0;
  logic [W-1:0] req_x = 0, req_y = 0;
  logic cu_start;
  logic [1:0] cu_op;
  logic [W-1:0] op_x, op_y;
  logic cu_finish = 0;
  logic [W-1:0] dp_hi = 0, dp_lo = 0;
  logic rsp_valid, rsp_ready = 0, rsp_timeout;
  logic [1:0] rsp_op;
  logic [W-1:0] rsp_hi, rsp_lo;
  int tests = 0, fails = 0, starts = 0, since = 0;
  req_t pend[$], launched[$];

  always #5 clk = ~clk;

  alu_op_dispatcher #(.WIDTH(W), .DEPTH(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_x(req_x), .req_y(req_y),
    .cu_start(cu_start), .cu_op(cu_op), .op_x(op_x), .op_y(op_y),
    .cu_finish(cu_finish), .dp_hi(dp_hi), .dp_lo(dp_lo),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_timeout(rsp_timeout)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; record accepted requests and observed launches
  task automatic step();
    bit acc;
    acc = req_valid && req_ready;
    @(posedge clk); #1;
    if (acc) begin
      pend.push_back({req_op, req_x, req_y});
      req_valid = 0;
    end
    if (cu_start) begin
      starts++;
      since = 0;
      launched.push_back({cu_op, op_x, op_y});
    end else since++;
  endtask

  task automatic push_req(logic [1:0] op, logic [W-1:0] x, logic [W-1:0] y);
    req_op = op; req_x = x; req_y = y; req_valid = 1;
    for (int i = 0; i < 300 && req_valid; i++) step();
    chk("push_accepted", {31'b0, req_valid}, 0);
    req_valid = 0;
  endtask

  function automatic logic [2*W-1:0] alu(req_t r);
    case (r.op)
      2'd0: return (2*W)'(r.x) + (2*W)'(r.y);
      2'd1: return (2*W)'(r.x) - (2*W)'(r.y);
      2'd2: return (2*W)'(r.x) * (2*W)'(r.y);
      default: return (r.y == 0) ? {r.x, {W{1'b1}}} : {r.x % r.y, r.x / r.y};
    endcase
  endfunction

  // run the oldest pending op: finish in WAIT cycle `delay` (or hang), then hold `bp` cycles before handshake
  task automatic run_one(int delay, int bp, bit hang);
    req_t e, l;
    logic [2*W-1:0] res;
    int n, s0;
    n = 0;
    while (launched.size() == 0 && n < 300) begin step(); n++; end
    chk("launch_seen", {31'b0, launched.size() != 0}, 1);
    chk("launch_pending", {31'b0, pend.size() != 0}, 1);
    if (launched.size() == 0 || pend.size() == 0) return;
    l = launched.pop_front();
    e = pend.pop_front();
    chk("cu_op", l.op, e.op);
    chk("op_x", l.x, e.x);
    chk("op_y", l.y, e.y);
    res = alu(e);
    s0 = starts;
    if (!hang) begin
      n = 0;
      while (since < delay && n < 300) begin step(); n++; end
      chk("finish_cycle", since, delay);
      chk("wait_no_rsp", rsp_valid, 0);
      chk("op_x_held", op_x, e.x);
      chk("op_y_held", op_y, e.y);
      cu_finish = 1;
      {dp_hi, dp_lo} = res;
      step();
      cu_finish = 0;
      dp_hi = W'($urandom);
      dp_lo = W'($urandom);
    end else begin
      n = 0;
      while (!rsp_valid && n < 300) begin step(); n++; end
      chk("tmo_latency", since, TMO + 1);
      res = '0;
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_timeout", rsp_timeout, hang);
    chk("rsp_op", rsp_op, e.op);
    chk("rsp_hi", rsp_hi, res[2*W-1:W]);
    chk("rsp_lo", rsp_lo, res[W-1:0]);
    repeat (bp) begin
      cu_finish = 1'($urandom_range(0, 1));
      dp_hi = W'($urandom);
      dp_lo = W'($urandom);
      step();
      chk("bp_valid", rsp_valid, 1);
      chk("bp_hi", rsp_hi, res[2*W-1:W]);
      chk("bp_lo", rsp_lo, res[W-1:0]);
      chk("bp_op_x", op_x, e.x);
    end
    cu_finish = 0;
    chk("no_relaunch", starts, s0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("rsp_cleared", rsp_valid, 0);
  endtask

  initial begin
    int s;
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int s, k;
    #12;
    chk("rst_ctrl", {cu_start, cu_op, op_x, op_y, rsp_valid, rsp_op, rsp_timeout, req_ready}, 0);
    chk("rst_data", {rsp_hi, rsp_lo}, 0);
    rst = 1;
    #1;
    chk("ready_after_rst", req_ready, 1);
    @(posedge clk); #1;

    s = starts;
    push_req(2'd0, 8'h05, 8'h03);
    run_one(4, 0, 0);
    chk("single_start", starts - s, 1);

    push_req(2'd2, W'($urandom), W'($urandom));
    push_req(2'd2, W'($urandom), W'($urandom));
    push_req(2'd2, W'($urandom), W'($urandom));
    chk("full_ready", req_ready, 0);
    req_op = 2'd2; req_x = W'($urandom); req_y = W'($urandom); req_valid = 1;
    run_one(6, 3, 0);
    chk("fourth_waiting", req_valid, 1);
    chk("ready_at_hs", req_ready, 0);
    run_one(5, 0, 0);
    chk("fourth_taken", req_valid, 0);
    run_one(7, 1, 0);
    run_one(3, 0, 0);

    push_req(2'd1, W'($urandom), W'($urandom));
    push_req(2'd3, W'($urandom), W'($urandom));
    run_one(0, 2, 1);
    run_one(10, 0, 0);

    push_req(2'd2, 8'h14, 8'he9);
    run_one(TMO, 0, 0);

    push_req(2'd0, W'($urandom), W'($urandom));
    push_req(2'd3, W'($urandom), W'($urandom));
    run_one(5, 10, 0);
    run_one(3, 0, 0);

    push_req(2'd0, W'($urandom), W'($urandom));
    push_req(2'd1, W'($urandom), W'($urandom));
    push_req(2'd2, W'($urandom), W'($urandom));
    step(); step();
    #3 rst = 0;
    #1;
    chk("arst_ctrl", {cu_start, cu_op, op_x, op_y, rsp_valid, rsp_op, rsp_timeout, req_ready}, 0);
    chk("arst_data", {rsp_hi, rsp_lo}, 0);
    step(); step();
    rst = 1;
    #1;
    chk("arst_ready", req_ready, 1);
    pend.delete();
    launched.delete();
    s = starts;
    repeat (8) step();
    chk("arst_no_start", starts, s);
    chk("arst_no_rsp", rsp_valid, 0);
    push_req(2'd0, 8'h21, 8'h42);
    run_one(2, 0, 0);

    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(1, 2);
      for (int j = 0; j < k; j++) push_req(2'($urandom), W'($urandom), W'($urandom));
      for (int j = 0; j < k; j++) run_one($urandom_range(1, 30), $urandom_range(0, 4), $urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
